// File: rtl/mmio_uart_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: register
// offsets, STATUS bit positions and the serialiser state encoding.
// Optional build macro: MMIO_UART_PARITY_EN.
package mmio_uart_pkg;

  // Register offsets are word indices taken from addr[3:2].
  localparam logic [1:0] OFF_TXDATA = 2'd0;
  localparam logic [1:0] OFF_STATUS = 2'd1;
  localparam logic [1:0] OFF_DIV    = 2'd2;

  // STATUS register bit positions.
  localparam int ST_FULL_BIT   = 0;
  localparam int ST_EMPTY_BIT  = 1;
  localparam int ST_BUSY_BIT   = 2;
  localparam int ST_OVF_BIT    = 3;
  localparam int ST_PAR_BIT    = 4;
  localparam int ST_CNT_LSB    = 8;

  // Serialiser states. S_PARITY is only entered when parity is built in.
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } uart_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with show-ahead read data. Push while full and pop while
// empty are ignored here, so callers may drive raw requests. DEPTH must be a
// power of two so the pointers wrap naturally.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      cnt;
  logic             push_ok;
  logic             pop_ok;

  // Full and empty come from the registered count, i.e. before any
  // same-cycle pop, so a push into a full FIFO is dropped even if a pop
  // happens in the same cycle.
  assign full    = (cnt == (AW+1)'(DEPTH));
  assign empty   = (cnt == '0);
  assign count   = cnt;
  assign rdata   = mem[rd_ptr];
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  // Storage array: no reset, contents are only meaningful below the count.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   cnt <= cnt + (AW+1)'(1);
        2'b01:   cnt <= cnt - (AW+1)'(1);
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter sitting on the CPU data port.
// Register window: TXDATA (push), STATUS, DIVISOR (clocks per bit).
// Optional build macro: MMIO_UART_PARITY_EN adds an even-parity bit.
//
// Bus handshake: a write is accepted in any cycle with wr=1 and the address
// inside the window; there is no back-pressure. A read is any cycle with
// wr=0; rdata/sel are registered and valid exactly one cycle later.
module mmio_uart_tx
  import mmio_uart_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_1000,
  parameter int          FIFO_DEPTH = 8,
  parameter logic [15:0] DIV_RESET  = 16'd16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        wr,
  output logic [31:0] rdata,
  output logic        sel,
  output logic        tx,
  output logic        tx_idle
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  // Bus decode
  logic        hit;
  logic [1:0]  off;
  logic        push_req;
  logic [31:0] rd_mux;
  logic        unused_ok;

  // Registers
  logic [15:0] div_reg;
  logic        overflow;

  // FIFO interface
  logic             fifo_pop;
  logic [7:0]       fifo_rdata;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CNT_W-1:0] fifo_count;

  // Serialiser
  uart_state_t state;
  logic [15:0] bit_cnt;
  logic [15:0] div_lat;
  logic [2:0]  bit_idx;
  logic [7:0]  shreg;
  logic        par_bit;
  logic        bit_end;

  assign hit       = (addr[31:4] == BASE_ADDR[31:4]);
  assign off       = addr[3:2];
  assign push_req  = wr && hit && (off == OFF_TXDATA);
  assign unused_ok = ^{addr[1:0], wdata[31:16]};

  assign bit_end  = (bit_cnt == 16'd0);
  // The serialiser takes a byte whenever it is idle, or at the end of a stop
  // bit so back-to-back frames have no gap.
  assign fifo_pop = !fifo_empty &&
                    ((state == S_IDLE) || ((state == S_STOP) && bit_end));
  assign tx_idle  = fifo_empty && (state == S_IDLE);

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_req),
    .wdata (wdata[7:0]),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Read-data mux for the addressed register; unlisted offsets read zero.
  always_comb begin
    rd_mux = 32'd0;
    case (off)
      OFF_STATUS: begin
        rd_mux[ST_FULL_BIT]  = fifo_full;
        rd_mux[ST_EMPTY_BIT] = fifo_empty;
        rd_mux[ST_BUSY_BIT]  = (state != S_IDLE);
        rd_mux[ST_OVF_BIT]   = overflow;
`ifdef MMIO_UART_PARITY_EN
        rd_mux[ST_PAR_BIT]   = 1'b1;
`else
        rd_mux[ST_PAR_BIT]   = 1'b0;
`endif
        rd_mux[ST_CNT_LSB +: CNT_W] = fifo_count;
      end
      OFF_DIV: rd_mux = {16'd0, div_reg};
      default: rd_mux = 32'd0;
    endcase
  end

  // Register writes, sticky overflow and the one-cycle registered read port.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_reg  <= DIV_RESET;
      overflow <= 1'b0;
      rdata    <= 32'd0;
      sel      <= 1'b0;
    end else begin
      sel   <= hit && !wr;
      rdata <= (hit && !wr) ? rd_mux : 32'd0;
      if (wr && hit) begin
        case (off)
          OFF_TXDATA: if (fifo_full) overflow <= 1'b1;
          OFF_STATUS: overflow <= 1'b0;
          // A divisor of zero would stall the bit counter, so clamp to 1.
          OFF_DIV:    div_reg <= (wdata[15:0] == 16'd0) ? 16'd1 : wdata[15:0];
          default:    ;
        endcase
      end
    end
  end

  // Bit-timing state machine; tx is registered and changes on bit boundaries.
  // The divisor is sampled only when a frame starts, so mid-frame writes
  // take effect on the following frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      tx      <= 1'b1;
      bit_cnt <= 16'd0;
      div_lat <= DIV_RESET;
      bit_idx <= 3'd0;
      shreg   <= 8'd0;
      par_bit <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          tx <= 1'b1;
          if (!fifo_empty) begin
            state   <= S_START;
            tx      <= 1'b0;
            shreg   <= fifo_rdata;
            par_bit <= ^fifo_rdata;
            div_lat <= div_reg;
            bit_cnt <= div_reg - 16'd1;
          end
        end
        S_START: begin
          if (bit_end) begin
            state   <= S_DATA;
            tx      <= shreg[0];
            bit_idx <= 3'd0;
            bit_cnt <= div_lat - 16'd1;
          end else begin
            bit_cnt <= bit_cnt - 16'd1;
          end
        end
        S_DATA: begin
          if (bit_end) begin
            bit_cnt <= div_lat - 16'd1;
            if (bit_idx == 3'd7) begin
`ifdef MMIO_UART_PARITY_EN
              state <= S_PARITY;
              tx    <= par_bit;
`else
              state <= S_STOP;
              tx    <= 1'b1;
`endif
            end else begin
              bit_idx <= bit_idx + 3'd1;
              shreg   <= {1'b0, shreg[7:1]};
              tx      <= shreg[1];
            end
          end else begin
            bit_cnt <= bit_cnt - 16'd1;
          end
        end
        S_PARITY: begin
          if (bit_end) begin
            state   <= S_STOP;
            tx      <= 1'b1;
            bit_cnt <= div_lat - 16'd1;
          end else begin
            bit_cnt <= bit_cnt - 16'd1;
          end
        end
        S_STOP: begin
          if (bit_end) begin
            if (!fifo_empty) begin
              state   <= S_START;
              tx      <= 1'b0;
              shreg   <= fifo_rdata;
              par_bit <= ^fifo_rdata;
              div_lat <= div_reg;
              bit_cnt <= div_reg - 16'd1;
            end else begin
              state <= S_IDLE;
              tx    <= 1'b1;
            end
          end else begin
            bit_cnt <= bit_cnt - 16'd1;
          end
        end
        default: begin
          state <= S_IDLE;
          tx    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed bench for mmio_uart_tx: reset values, single-frame timing,
// FIFO overflow with back-to-back frames, divisor change mid-frame,
// reset mid-frame, and window decode / read latency.
module tb_mmio_uart_tx;

`ifdef MMIO_UART_PARITY_EN
  localparam int          NB   = 11;
  localparam logic [31:0] FEAT = 32'h10;
`else
  localparam int          NB   = 10;
  localparam logic [31:0] FEAT = 32'h0;
`endif

  localparam logic [31:0] A_TX  = 32'h0000_1000;
  localparam logic [31:0] A_ST  = 32'h0000_1004;
  localparam logic [31:0] A_DIV = 32'h0000_1008;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        wr;
  logic [31:0] rdata;
  logic        sel;
  logic        tx;
  logic        tx_idle;

  int n_cmp = 0;
  int n_bad = 0;

  mmio_uart_tx dut (
    .clk     (clk),
    .rst     (rst),
    .addr    (addr),
    .wdata   (wdata),
    .wr      (wr),
    .rdata   (rdata),
    .sel     (sel),
    .tx      (tx),
    .tx_idle (tx_idle)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One write per clock edge; consecutive calls give back-to-back writes.
  task automatic wr_reg(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    addr  = a;
    wdata = d;
    wr    = 1'b1;
    @(posedge clk);
    #1;
    wr    = 1'b0;
    addr  = 32'h0;
    wdata = 32'h0;
  endtask

  // Read: address presented for one edge, result sampled at the next negedge.
  task automatic rd_reg(input logic [31:0] a, output logic [31:0] d, output logic s);
    @(negedge clk);
    addr = a;
    wr   = 1'b0;
    @(posedge clk);
    #1;
    addr = 32'h0;
    @(negedge clk);
    d = rdata;
    s = sel;
  endtask

  // Sample one frame at bit centres. phase = frame cycle index of the last
  // negedge already consumed (cycle 0 is the first negedge with tx low).
  task automatic rx_frame(input int div, input int phase, output logic [7:0] b);
    int cur;
    logic [NB-1:0] bits;
    cur = phase;
    for (int k = 0; k < NB; k++) begin
      repeat (k*div + div/2 - cur) @(negedge clk);
      cur = k*div + div/2;
      bits[k] = tx;
    end
    check("start_bit", 32'(bits[0]), 32'd0);
    check("stop_bit", 32'(bits[NB-1]), 32'd1);
`ifdef MMIO_UART_PARITY_EN
    check("parity_bit", 32'(bits[9]), 32'(^bits[8:1]));
`endif
    b = bits[8:1];
  endtask

  // Bounded wait for the next start bit; returns negedges consumed.
  task automatic wait_start(input int limit, output int waited);
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (tx !== 1'b0 && waited < limit);
  endtask

  initial begin
    logic [31:0]   d;
    logic          s;
    logic [7:0]    b;
    int            w;
    logic          went_low;
    logic [NB-1:0] exp_frame;

    rst = 1'b1; wr = 1'b0; addr = 32'h0; wdata = 32'h0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_tx", 32'(tx), 32'd1);
    check("rst_tx_idle", 32'(tx_idle), 32'd1);
    check("rst_sel", 32'(sel), 32'd0);
    check("rst_rdata", rdata, 32'd0);
    rd_reg(A_ST, d, s);
    check("rst_status", d, 32'h2 | FEAT);
    check("rst_status_sel", 32'(s), 32'd1);
    rd_reg(A_DIV, d, s);
    check("rst_div", d, 32'd16);

    // Single byte 0x55 at DIV=4, checked every cycle of the frame
`ifdef MMIO_UART_PARITY_EN
    exp_frame = 11'b100_1010_1010;
`else
    exp_frame = 10'b10_1010_1010;
`endif
    wr_reg(A_DIV, 32'd4);
    wr_reg(A_TX, 32'h55);
    @(negedge clk);
    check("push_edge_tx_high", 32'(tx), 32'd1);
    for (int c = 0; c < NB*4; c++) begin
      @(negedge clk);
      check($sformatf("frame55_c%0d", c), 32'(tx), 32'(exp_frame[c/4]));
    end
    check("frame55_idle_low_last", 32'(tx_idle), 32'd0);
    @(negedge clk);
    check("frame55_idle_back", 32'(tx_idle), 32'd1);

    // Overflow: ten back-to-back pushes at DIV=100
    wr_reg(A_DIV, 32'd100);
    for (int i = 0; i < 10; i++) wr_reg(A_TX, 32'(i));
    rd_reg(A_ST, d, s);
    check("ovf_status", d, 32'h0000_080D | FEAT);
    rx_frame(100, 9, b);
    check("ovf_byte0", 32'(b), 32'd0);
    for (int i = 1; i <= 8; i++) begin
      wait_start(300, w);
      check($sformatf("ovf_gap%0d", i), 32'(w), 32'd50);
      rx_frame(100, 0, b);
      check($sformatf("ovf_byte%0d", i), 32'(b), 32'(i));
    end
    went_low = 1'b0;
    repeat (300) begin
      @(negedge clk);
      if (tx !== 1'b1) went_low = 1'b1;
    end
    check("ovf_no_tenth_frame", 32'(went_low), 32'd0);
    check("ovf_tx_idle", 32'(tx_idle), 32'd1);
    rd_reg(A_ST, d, s);
    check("ovf_sticky", d, 32'hA | FEAT);
    wr_reg(A_ST, 32'h0);
    rd_reg(A_ST, d, s);
    check("ovf_cleared", d, 32'h2 | FEAT);

    // Divisor change mid-frame
    wr_reg(A_DIV, 32'd8);
    wr_reg(A_TX, 32'hA5);
    wr_reg(A_DIV, 32'd2);
    wr_reg(A_TX, 32'h3C);
    rx_frame(8, 0, b);
    check("divchg_byteA5", 32'(b), 32'hA5);
    wait_start(40, w);
    check("divchg_old_len", 32'(w), 32'd4);
    rx_frame(2, 0, b);
    check("divchg_byte3C", 32'(b), 32'h3C);
    @(negedge clk);
    check("divchg_new_len", 32'(tx_idle), 32'd1);

    // Reset during data bit 3 of 0xF0, with a second byte queued
    wr_reg(A_DIV, 32'd4);
    wr_reg(A_TX, 32'hF0);
    wr_reg(A_TX, 32'h0F);
    repeat (18) @(negedge clk);
    check("midrst_bit3", 32'(tx), 32'd0);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("midrst_tx_high", 32'(tx), 32'd1);
    check("midrst_tx_idle", 32'(tx_idle), 32'd1);
    rd_reg(A_ST, d, s);
    check("midrst_status", d, 32'h2 | FEAT);
    rd_reg(A_DIV, d, s);
    check("midrst_div", d, 32'd16);
    went_low = 1'b0;
    repeat (200) begin
      @(negedge clk);
      if (tx !== 1'b1) went_low = 1'b1;
    end
    check("midrst_no_frames", 32'(went_low), 32'd0);

    // Window decode and read latency
    rd_reg(32'h0000_100C, d, s);
    check("win_0c_rdata", d, 32'd0);
    check("win_0c_sel", 32'(s), 32'd1);
    rd_reg(32'h0000_1010, d, s);
    check("win_1010_rdata", d, 32'd0);
    check("win_1010_sel", 32'(s), 32'd0);
    rd_reg(A_TX, d, s);
    check("win_txdata_reads0", d, 32'd0);
    wr_reg(32'h0000_100C, 32'hFFFF_FFFF);
    rd_reg(A_DIV, d, s);
    check("win_0c_write_ignored", d, 32'd16);
    wr_reg(A_DIV, 32'h0);
    rd_reg(32'h0000_100B, d, s);
    check("div0_reads1", d, 32'd1);
    wr_reg(32'h0000_1018, 32'h55);
    rd_reg(A_DIV, d, s);
    check("outside_write_ignored", d, 32'd1);
    wr_reg(A_DIV, 32'hABCD_1234);
    rd_reg(A_DIV, d, s);
    check("div_upper_bits_zero", d, 32'h0000_1234);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
